// File: rtl/instr_mem_responder.sv
// instr_mem_responder: fixed-latency instruction memory with a program-load write port.
// Define IMEM_ALIGN_CHECK_EN to also fault fetches whose byte address is not word aligned.
`ifndef WORD
`define WORD 32
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif
module instr_mem_responder #(
  parameter int DEPTH = 64,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [`WORD-1:0]      req_addr,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [`INSTR_LEN-1:0] instruction,
  output logic                  fault,
  input  logic                  ld_en,
  input  logic [`WORD-1:0]      ld_addr,
  input  logic [`INSTR_LEN-1:0] ld_data
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic [`INSTR_LEN-1:0] mem [DEPTH];
  logic [`INSTR_LEN-1:0] cap_data, rd_data;
  logic cap_fault, req_fault, req_oob, ld_oob, accept, unused_lo;
  assign req_oob = |req_addr[`WORD-1:AW+2];
  assign ld_oob = |ld_addr[`WORD-1:AW+2];
`ifdef IMEM_ALIGN_CHECK_EN
  assign req_fault = req_oob | (|req_addr[1:0]);
`else
  assign req_fault = req_oob;
`endif
  assign unused_lo = ^{req_addr[1:0], ld_addr[1:0]};
  assign rd_data = req_fault ? '0 : mem[req_addr[AW+1:2]];
  assign req_ready = state == IDLE && !reset;
  assign resp_valid = state == RESP && !reset;
  assign accept = req_valid && req_ready;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (accept ? (LATENCY == 1 ? RESP : WAIT) : IDLE) :
                state == WAIT ? (cnt <= 4'd1 ? RESP : WAIT) : IDLE;
  end
  // Outputs only move on RESP entry; with LATENCY=1 that is the accepting edge itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      instruction <= '0;
      fault <= 1'b0;
      cap_data <= '0;
      cap_fault <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= 4'(LATENCY - 1);
        cap_data <= rd_data;
        cap_fault <= req_fault;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state_nxt == RESP) begin
        instruction <= state == IDLE ? rd_data : cap_data;
        fault <= state == IDLE ? req_fault : cap_fault;
      end
    end
  end
  // Storage survives reset and accepts loads in every state.
  always_ff @(posedge clk)
    if (ld_en && !ld_oob) mem[ld_addr[AW+1:2]] <= ld_data;
endmodule
